// File: rtl/multi_breather_pkg.sv
// Shared definitions for the multi-channel breathing/blink LED driver.
package multi_breather_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_BLINK   = 2'd3
  } mode_t;

endpackage

// File: rtl/multi_breather_channel.sv
// One LED channel: ramp prescaler, triangle phase accumulator and registered
// PWM compare against the shared carrier.
module breath_channel
  import multi_breather_pkg::*;
#(
  parameter int PWM_BITS = 16,
  parameter int DIV_BITS = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  mode_t               load_mode,
  input  logic [DIV_BITS-1:0] load_rate,
  input  logic [PWM_BITS:0]   load_phase,
  input  logic [PWM_BITS-1:0] carrier,
  output logic                pwm
);

  mode_t               mode;
  logic [DIV_BITS-1:0] rate;
  logic [DIV_BITS-1:0] presc;
  logic [PWM_BITS:0]   phase;
  logic [PWM_BITS-1:0] level;
  logic                pwm_next;

  // Upper phase half counts the level back down, giving a triangle.
  always_comb begin
    level = phase[PWM_BITS] ? ~phase[PWM_BITS-1:0] : phase[PWM_BITS-1:0];
  end

  always_comb begin
    pwm_next = 1'b0;
    case (mode)
      MODE_OFF:     pwm_next = 1'b0;
      MODE_ON:      pwm_next = 1'b1;
      MODE_BREATHE: pwm_next = (carrier < level);
      MODE_BLINK:   pwm_next = phase[PWM_BITS];
      default:      pwm_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode  <= MODE_OFF;
      rate  <= '0;
      presc <= '0;
      phase <= '0;
      pwm   <= 1'b0;
    end else begin
      pwm <= pwm_next;
      if (load) begin
        mode  <= load_mode;
        rate  <= load_rate;
        presc <= '0;
        phase <= load_phase;
      end else if (presc == rate) begin
        presc <= '0;
        phase <= phase + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_breather.sv
// Multi-channel breathing/blink LED driver: shared PWM carrier, one pending
// configuration slot, and CH breath_channel instances.
module multi_breather
  import multi_breather_pkg::*;
#(
  parameter  int CH       = 3,
  parameter  int PWM_BITS = 16,
  parameter  int DIV_BITS = 10,
  localparam int CH_W     = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [DIV_BITS-1:0] cfg_rate,
  input  logic [PWM_BITS:0]   cfg_phase,
  output logic [CH-1:0]       pwm_out
);

  logic [PWM_BITS-1:0] carrier;
  logic                pending;
  logic [CH_W-1:0]     pend_ch;
  mode_t               pend_mode;
  logic [DIV_BITS-1:0] pend_rate;
  logic [PWM_BITS:0]   pend_phase;
  logic                accept;
  logic                commit;

  // Handshake: a transfer happens on any cycle with cfg_valid && cfg_ready;
  // cfg_ready stays low while the single pending slot is full and returns
  // the cycle after that slot commits at the carrier wrap.
  assign cfg_ready = ~pending;
  assign accept    = cfg_valid && cfg_ready;
  assign commit    = pending && (carrier == {PWM_BITS{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      carrier    <= '0;
      pending    <= 1'b0;
      pend_ch    <= '0;
      pend_mode  <= MODE_OFF;
      pend_rate  <= '0;
      pend_phase <= '0;
    end else begin
      carrier <= carrier + 1'b1;
      if (accept) begin
        pending    <= 1'b1;
        pend_ch    <= cfg_ch;
        pend_mode  <= mode_t'(cfg_mode);
        pend_rate  <= cfg_rate;
        pend_phase <= cfg_phase;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

  // An out-of-range pend_ch matches no instance, so its commit is a no-op.
  for (genvar i = 0; i < CH; i++) begin : g_ch
    breath_channel #(
      .PWM_BITS(PWM_BITS),
      .DIV_BITS(DIV_BITS)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .load      (commit && (pend_ch == CH_W'(i))),
      .load_mode (pend_mode),
      .load_rate (pend_rate),
      .load_phase(pend_phase),
      .carrier   (carrier),
      .pwm       (pwm_out[i])
    );
  end

endmodule
